// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// bit positions of the fetch exception and stall vectors.
package if_stage_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } if_state_e;

  localparam int FETCH_MISALIGN = 0;
  localparam int FETCH_FAULT    = 1;
  localparam int IF_STALL       = 0;

endpackage

// File: rtl/if_pc_chk.sv
// Combinational fetch-address checker: flags a misaligned PC and a PC
// outside the instruction memory window.
module if_pc_chk #(
  parameter logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] IMEM_SIZE = 64'h0000_0000_0800_0000
) (
  input  logic [63:0] pc,
  output logic        misalign,
  output logic        fault
);

  // One extra bit so a window touching the top of the address space cannot wrap.
  localparam logic [64:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  assign misalign = (pc[1:0] != 2'b00);
  assign fault    = (pc < IMEM_BASE) || ({1'b0, pc} >= IMEM_LIMIT);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, sequences boot, trap and
// branch redirects (including redirects deferred by a stall) and drives the SRAM.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] IMEM_SIZE = 64'h0000_0000_0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [63:0] new_pc,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic [31:0] csr_vec_h,
  output logic        inst_sram_en,
  output logic [7:0]  inst_sram_we,
  output logic [63:0] inst_sram_addr,
  output logic [63:0] inst_sram_wdata
);

  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  if_state_e   state_q, state_d;

  logic        if_stall;
  logic        misalign, fault;
  logic        unused_stall;

  assign if_stall     = stall[IF_STALL];
  assign unused_stall = ^stall[5:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      pend_q  <= 64'd0;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    state_d = state_q;
    if (flush) begin
      pc_d    = new_pc;
      valid_d = 1'b1;
      pend_d  = 64'd0;
      state_d = RUN;
    end else if (state_q == BOOT) begin
      valid_d = 1'b1;
      state_d = RUN;
    end else if (br_e && !if_stall) begin
      pc_d    = br_addr;
      state_d = RUN;
    end else if (br_e) begin
      // Youngest redirect wins: a new branch while pending overwrites the target.
      pend_d  = br_addr;
      state_d = PEND;
    end else if (state_q == PEND) begin
      if (!if_stall) begin
        pc_d    = pend_q;
        state_d = RUN;
      end
    end else if (!if_stall) begin
      pc_d    = pc_q + 64'd4;
      state_d = RUN;
    end
  end

  if_pc_chk #(
    .IMEM_BASE(IMEM_BASE),
    .IMEM_SIZE(IMEM_SIZE)
  ) u_pc_chk (
    .pc      (pc_q),
    .misalign(misalign),
    .fault   (fault)
  );

  always_comb begin
    csr_vec_h                 = 32'd0;
    csr_vec_h[FETCH_MISALIGN] = valid_q & misalign;
    csr_vec_h[FETCH_FAULT]    = valid_q & fault;
  end

  assign pc              = pc_q;
  assign pc_valid        = valid_q;
  // Held during stall so decode can re-capture the same word.
  assign inst_sram_en    = valid_q & ~csr_vec_h[FETCH_MISALIGN] & ~csr_vec_h[FETCH_FAULT];
  assign inst_sram_addr  = {pc_q[63:3], 3'b000};
  assign inst_sram_we    = 8'd0;
  assign inst_sram_wdata = 64'd0;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected outputs from a
// behavioural model; a monitor pops and compares after every clock edge.
module tb_if_stage;

  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] IMEM_SIZE = 64'h0000_0000_0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] new_pc = 64'd0;
  logic [5:0]  stall = 6'd0;
  logic        br_e = 1'b0;
  logic [63:0] br_addr = 64'd0;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] csr_vec_h;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_we;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;

  if_stage #(
    .RESET_PC (RESET_PC),
    .IMEM_BASE(IMEM_BASE),
    .IMEM_SIZE(IMEM_SIZE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall          (stall),
    .br_e           (br_e),
    .br_addr        (br_addr),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .csr_vec_h      (csr_vec_h),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic [31:0] csr;
    logic        en;
    logic [63:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Reference model state: architectural view, not an FSM encoding.
  logic [63:0] m_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic        m_booting = 1'b1;
  logic        m_has_pend = 1'b0;
  logic [63:0] m_pend = 64'd0;

  function automatic exp_t predict();
    exp_t e;
    logic mis, flt;
    mis = (m_pc % 4) != 0;
    flt = (m_pc < IMEM_BASE) || (m_pc >= IMEM_BASE + IMEM_SIZE);
    e.pc    = m_pc;
    e.valid = m_valid;
    e.csr   = 32'd0;
    if (m_valid && mis) e.csr = e.csr + 32'd1;
    if (m_valid && flt) e.csr = e.csr + 32'd2;
    e.en    = m_valid && !mis && !flt;
    e.addr  = m_pc - (m_pc % 8);
    return e;
  endfunction

  task automatic step(input logic rst, input logic fl, input logic [63:0] npc,
                      input logic [5:0] st, input logic br, input logic [63:0] ba);
    @(negedge clk);
    rst_n = ~rst; flush = fl; new_pc = npc; stall = st; br_e = br; br_addr = ba;
    if (rst) begin
      m_pc = RESET_PC; m_valid = 1'b0; m_booting = 1'b1; m_has_pend = 1'b0;
    end else if (fl) begin
      m_pc = npc; m_valid = 1'b1; m_booting = 1'b0; m_has_pend = 1'b0;
    end else if (m_booting) begin
      m_valid = 1'b1; m_booting = 1'b0;
    end else if (br) begin
      if (st[0]) begin
        m_pend = ba; m_has_pend = 1'b1;
      end else begin
        m_pc = ba; m_has_pend = 1'b0;
      end
    end else if (m_has_pend) begin
      if (!st[0]) begin
        m_pc = m_pend; m_has_pend = 1'b0;
      end
    end else if (!st[0]) begin
      m_pc = m_pc + 64'd4;
    end
    exp_q.push_back(predict());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 6'd0, 1'b0, 64'd0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a fetch slot; compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("pc", pc, e.pc);
        chk("pc_valid", {63'd0, pc_valid}, {63'd0, e.valid});
        chk("csr_vec_h", {32'd0, csr_vec_h}, {32'd0, e.csr});
        chk("sram_en", {63'd0, inst_sram_en}, {63'd0, e.en});
        chk("sram_addr", inst_sram_addr, e.addr);
        chk("sram_we", {56'd0, inst_sram_we}, 64'd0);
        chk("sram_wdata", inst_sram_wdata, 64'd0);
        $display("txn %0d pc=%h valid=%0d csr=%0h en=%0d addr=%h",
                 txn, pc, pc_valid, csr_vec_h, inst_sram_en, inst_sram_addr);
      end
    end
  end

  function automatic logic [63:0] rand_target();
    case ($urandom_range(0, 9))
      0:       return IMEM_BASE + 64'({$urandom_range(0, 1023), 2'b10});
      1:       return 64'h0000_0000_0000_1000;
      2:       return IMEM_BASE + IMEM_SIZE - 64'd4;
      3:       return IMEM_BASE + IMEM_SIZE;
      4:       return IMEM_BASE - 64'd4;
      5:       return 64'hFFFF_FFFF_FFFF_FFFC;
      default: return IMEM_BASE + 64'({$urandom_range(0, 4095), 2'b00});
    endcase
  endfunction

  initial begin
    // Reset and boot, then the directed scenarios.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 64'd0);
    idle(5);
    step(1'b0, 1'b0, 64'd0, 6'd0, 1'b1, 64'h8000_0100);
    idle(2);
    step(1'b0, 1'b0, 64'd0, 6'd1, 1'b1, 64'h8000_0200);
    step(1'b0, 1'b0, 64'd0, 6'd1, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0, 6'd1, 1'b0, 64'd0);
    idle(2);
    step(1'b0, 1'b0, 64'd0, 6'd1, 1'b1, 64'h8000_0300);
    step(1'b0, 1'b1, 64'h8000_0400, 6'd1, 1'b1, 64'h8000_0200);
    idle(2);
    step(1'b0, 1'b0, 64'd0, 6'd0, 1'b1, 64'h8000_0102);
    idle(1);
    step(1'b0, 1'b0, 64'd0, 6'd0, 1'b1, 64'h0000_1000);
    idle(1);
    step(1'b0, 1'b0, 64'd0, 6'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(2);
    step(1'b0, 1'b1, 64'h8000_0000, 6'd0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 64'd0, 6'd1, 1'b1, 64'h8000_0500);
    step(1'b1, 1'b0, 64'd0, 6'd1, 1'b0, 64'd0);
    step(1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 64'd0);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_fl, r_br;
      logic [5:0]  r_st;
      r_rst = ($urandom_range(0, 199) == 0);
      r_fl  = ($urandom_range(0, 24) == 0);
      r_br  = ($urandom_range(0, 5) == 0);
      r_st  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) r_st[0] = 1'b0;
      step(r_rst, r_fl, rand_target(), r_st, r_br, rand_target());
    end
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
